// File: rtl/voice_pkg.sv
// Shared types, constants and helpers for the voice scheduler and its mix accumulator.
package voice_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int SAMPLE_W_DEFAULT = 16;
   // Three guard bits hold the sum of up to eight full-scale voices without wrap.
   localparam int ACC_GUARD        = 3;
   localparam int MAX_VOICES       = 8;
   localparam logic [3:0] NO_VOICE = 4'd8;

   // Clamp a signed sum to the range of a width-bit signed value.
   function automatic logic signed [31:0] saturate(input logic signed [31:0] acc,
                                                   input int width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (acc > hi)
         return hi;
      else if (acc < lo)
         return lo;
      else
         return acc;
   endfunction

   // Lowest set bit of mask strictly above position 'from'; NO_VOICE when none.
   function automatic logic [3:0] next_set_bit(input logic [MAX_VOICES-1:0] mask,
                                               input int from);
      logic [3:0] r;
      r = NO_VOICE;
      for (int i = MAX_VOICES - 1; i >= 0; i--) begin
         if (mask[i] && (i > from))
            r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/mix_accumulator.sv
// Signed accumulator for one mix frame plus the saturated, held mix output register.
module mix_accumulator
   import voice_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
   parameter int ACC_W    = SAMPLE_W + ACC_GUARD
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_clear,
   input  logic                       i_add,
   input  logic                       i_load,
   input  logic signed [SAMPLE_W-1:0] i_sample,
   output logic        [SAMPLE_W-1:0] o_mix
);

   logic signed [ACC_W-1:0]    r_acc;
   logic signed [ACC_W-1:0]    w_acc_next;
   logic        [SAMPLE_W-1:0] w_sat;
   logic        [SAMPLE_W-1:0] r_mix;

   always_comb begin
      w_acc_next = r_acc;
      if (i_clear)
         w_acc_next = '0;
      else if (i_add)
         w_acc_next = r_acc + ACC_W'(i_sample);
   end

   // Load from the next-value path so the final voice's sample lands in the same edge.
   assign w_sat = SAMPLE_W'(saturate(32'(w_acc_next), SAMPLE_W));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
         r_mix <= '0;
      end else begin
         r_acc <= w_acc_next;
         if (i_load)
            r_mix <= w_sat;
      end
   end

   assign o_mix = r_mix;

endmodule

// File: rtl/voice_scheduler.sv
// Walks the active voices once per frame request, collects one sample from each and
// emits a saturated mix. Handshake: gen_sample pulses one cycle; voice_ready is honoured only in WAIT.
module voice_scheduler
   import voice_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
   parameter int TIMEOUT    = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_req,
   input  logic [NUM_VOICES-1:0]          voice_active,
   output logic [NUM_VOICES-1:0]          gen_sample,
   input  logic [NUM_VOICES-1:0]          voice_ready,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   output logic [SAMPLE_W-1:0]            mix_out,
   output logic                           mix_valid,
   output logic                           busy,
   output logic                           overrun,
   output logic                           timeout_err,
   output state_t                         dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam int ACC_W = SAMPLE_W + ACC_GUARD;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [NUM_VOICES-1:0]       r_mask;
   logic [3:0]                  r_idx;
   logic [CNT_W-1:0]            r_cnt;
   logic                        r_overrun;
   logic                        r_timeout_err;

   logic [MAX_VOICES-1:0]       w_active_ext;
   logic [MAX_VOICES-1:0]       w_mask_ext;
   logic [3:0]                  w_first;
   logic [3:0]                  w_next;
   logic                        w_sel_ready;
   logic signed [SAMPLE_W-1:0]  w_sel_sample;
   logic [NUM_VOICES-1:0]       w_gen;
   logic                        w_clear;
   logic                        w_add;
   logic                        w_load;
   logic                        w_exit;
   logic                        w_timeout;

   always_comb begin
      w_active_ext                 = '0;
      w_mask_ext                   = '0;
      w_active_ext[NUM_VOICES-1:0] = voice_active;
      w_mask_ext[NUM_VOICES-1:0]   = r_mask;
   end

   assign w_first = next_set_bit(w_active_ext, -1);
   assign w_next  = next_set_bit(w_mask_ext, int'(r_idx));

   always_comb begin
      w_sel_ready  = 1'b0;
      w_sel_sample = '0;
      w_gen        = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (r_idx == 4'(i)) begin
            w_sel_ready  = voice_ready[i];
            w_sel_sample = voice_sample[i*SAMPLE_W +: SAMPLE_W];
            w_gen[i]     = (r_state == S_ISSUE);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_add        = 1'b0;
      w_load       = 1'b0;
      w_exit       = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_req) begin
               w_clear = 1'b1;
               if (w_first == NO_VOICE) begin
                  w_state_next = S_DONE;
                  w_load       = 1'b1;
               end else begin
                  w_state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: w_state_next = S_WAIT;
         S_WAIT: begin
            // Ready wins over the timeout in the last counted cycle.
            if (w_sel_ready) begin
               w_add  = 1'b1;
               w_exit = 1'b1;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_exit    = 1'b1;
               w_timeout = 1'b1;
            end
            if (w_exit) begin
               if (w_next == NO_VOICE) begin
                  w_state_next = S_DONE;
                  w_load       = 1'b1;
               end else begin
                  w_state_next = S_ISSUE;
               end
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_mask        <= '0;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_overrun <= frame_req && (r_state != S_IDLE);
         if (w_timeout)
            r_timeout_err <= 1'b1;
         if (r_state == S_IDLE && frame_req) begin
            r_mask <= voice_active;
            r_idx  <= w_first;
         end else if (w_exit) begin
            r_idx <= w_next;
         end
         if (r_state == S_ISSUE)
            r_cnt <= '0;
         else if (r_state == S_WAIT)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   mix_accumulator #(
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
   ) u_mix (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_clear),
      .i_add    (w_add),
      .i_load   (w_load),
      .i_sample (w_sel_sample),
      .o_mix    (mix_out)
   );

   assign gen_sample  = w_gen;
   assign mix_valid   = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign overrun     = r_overrun;
   assign timeout_err = r_timeout_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_voice_scheduler.sv
// Frame-level bench for voice_scheduler: responder models for three voices, scoreboard queues
// for gen_sample order, mix value and latency, plus hand sequences for overrun and reset.
module tb_voice_scheduler;
   import voice_pkg::*;

   localparam int NV = 3;
   localparam int SW = 16;
   localparam int TO = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             frame_req = 1'b0;
   logic [NV-1:0]    voice_active = '0;
   logic [NV-1:0]    gen_sample;
   logic [NV-1:0]    voice_ready = '0;
   logic [NV*SW-1:0] voice_sample = '0;
   logic [SW-1:0]    mix_out;
   logic             mix_valid;
   logic             busy;
   logic             overrun;
   logic             timeout_err;
   state_t           dbg_state;

   voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_req    (frame_req),
      .voice_active (voice_active),
      .gen_sample   (gen_sample),
      .voice_ready  (voice_ready),
      .voice_sample (voice_sample),
      .mix_out      (mix_out),
      .mix_valid    (mix_valid),
      .busy         (busy),
      .overrun      (overrun),
      .timeout_err  (timeout_err),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int neg_cnt = 0;
   int ovr_cnt = 0;
   int last_ovr = -1;
   int dly [NV];
   int rem [NV];

   logic [SW-1:0] exp_q [$];
   int            exp_lat_q [$];
   int            start_q [$];
   logic [NV-1:0] exp_gen_q [$];

   typedef struct {
      logic [NV-1:0] mask;
      int s0, s1, s2;
      int d0, d1, d2;
      int exp_mix;
      int exp_lat;
      logic exp_terr;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Responder: a voice with delay d raises ready during its d-th WAIT cycle; d=0 never answers.
   always @(negedge clk) begin
      for (int i = 0; i < NV; i++) begin
         voice_ready[i] = 1'b0;
         if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) voice_ready[i] = 1'b1;
         end
         if (gen_sample[i] && dly[i] > 0) rem[i] = dly[i];
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      neg_cnt++;
      if (reset) begin
         if (gen_sample != '0) begin
            if (exp_gen_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL gen_sample: unexpected pulse %b", gen_sample);
            end else begin
               check("gen_sample", 32'(gen_sample), 32'(exp_gen_q.pop_front()));
            end
         end
         if (mix_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL mix_valid: unexpected pulse, mix_out %0d", $signed(mix_out));
            end else begin
               check("mix_out", 32'(mix_out), 32'(exp_q.pop_front()));
               check("latency", neg_cnt - start_q.pop_front(), exp_lat_q.pop_front());
            end
         end
         if (overrun) begin
            ovr_cnt++;
            last_ovr = neg_cnt;
         end
      end
   end

   function automatic int clamp(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic vec_t make_vec(input logic [NV-1:0] m, input int s0, input int s1, input int s2,
                                     input int d0, input int d1, input int d2, input logic terr);
      vec_t v;
      int sum;
      int lat;
      int s [NV];
      int d [NV];
      s[0] = s0; s[1] = s1; s[2] = s2;
      d[0] = d0; d[1] = d1; d[2] = d2;
      sum = 0;
      lat = 1;
      for (int i = 0; i < NV; i++) begin
         if (m[i]) begin
            lat += 1 + ((d[i] == 0) ? TO : d[i]);
            if (d[i] != 0) sum += s[i];
         end
      end
      v.mask = m; v.s0 = s0; v.s1 = s1; v.s2 = s2;
      v.d0 = d0; v.d1 = d1; v.d2 = d2;
      v.exp_mix = clamp(sum); v.exp_lat = lat; v.exp_terr = terr;
      return v;
   endfunction

   task automatic push_frame(input logic [NV-1:0] m, input int mix, input int lat);
      exp_q.push_back(SW'(mix));
      exp_lat_q.push_back(lat);
      start_q.push_back(neg_cnt);
      for (int i = 0; i < NV; i++)
         if (m[i]) exp_gen_q.push_back(NV'(1) << i);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL frame_timeout: %0d frames still pending", exp_q.size());
         exp_q.delete(); exp_lat_q.delete(); start_q.delete(); exp_gen_q.delete();
      end
      @(negedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk); #1;
      voice_active = v.mask;
      voice_sample = {SW'(v.s2), SW'(v.s1), SW'(v.s0)};
      dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2;
      push_frame(v.mask, v.exp_mix, v.exp_lat);
      frame_req = 1'b1;
      @(negedge clk); #1;
      frame_req = 1'b0;
      wait_done();
      check("timeout_err", 32'(timeout_err), 32'(v.exp_terr));
      check("busy_after_frame", 32'(busy), 32'd0);
   endtask

   int ovr_before;
   int t_drop;

   initial begin
      for (int i = 0; i < NV; i++) begin dly[i] = 0; rem[i] = 0; end

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      check("rst_gen_sample", 32'(gen_sample), 32'd0);
      check("rst_mix_out", 32'(mix_out), 32'd0);
      check("rst_mix_valid", 32'(mix_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      reset = 1'b1;

      // Hand-derived vectors: mask, samples, ready delays, mix, latency, sticky error.
      vecs.push_back('{3'b111,   1000,  -200,     50, 1, 1, 1,    850,  7, 1'b0});
      vecs.push_back('{3'b101,    300,   999,   -700, 2, 1, 3,   -400,  8, 1'b0});
      vecs.push_back('{3'b000,    123,   456,    789, 1, 1, 1,      0,  1, 1'b0});
      vecs.push_back('{3'b111,  20000, 20000,  20000, 1, 2, 1,  32767,  8, 1'b0});
      vecs.push_back('{3'b111, -20000,-20000, -20000, 3, 1, 1, -32768,  9, 1'b0});
      vecs.push_back('{3'b010,      5,-32768,      7, 1, 1, 1, -32768,  3, 1'b0});
      vecs.push_back('{3'b110,      0, 32767,      1, 1, 1, 1,  32767,  5, 1'b0});
      for (int r = 0; r < 4; r++)
         vecs.push_back(make_vec(NV'($urandom_range(0, 7)),
                                 int'($urandom_range(0, 65535)) - 32768,
                                 int'($urandom_range(0, 65535)) - 32768,
                                 int'($urandom_range(0, 65535)) - 32768,
                                 int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                                 int'($urandom_range(1, 4)), 1'b0));
      // Voice 1 never answers: 1 + TIMEOUT cycles for that voice, contributes 0.
      vecs.push_back('{3'b111,   1000,     5,      7, 1, 0, 1,   1007, 70, 1'b1});
      vecs.push_back('{3'b011,    100,  -150,      0, 1, 1, 1,    -50,  5, 1'b1});

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while waiting on a silent voice: outputs drop at once, no mix_valid.
      @(negedge clk); #1;
      voice_active = 3'b111;
      dly[0] = 0; dly[1] = 0; dly[2] = 0;
      exp_gen_q.push_back(3'b001);
      frame_req = 1'b1;
      @(negedge clk); #1;
      frame_req = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("busy_mid_wait", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("arst_gen_sample", 32'(gen_sample), 32'd0);
      check("arst_mix_out", 32'(mix_out), 32'd0);
      check("arst_mix_valid", 32'(mix_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_overrun", 32'(overrun), 32'd0);
      check("arst_timeout_err", 32'(timeout_err), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      reset = 1'b1;
      check("arst_gen_q_drained", 32'(exp_gen_q.size()), 32'd0);
      run_vec('{3'b111, 11, 22, 33, 1, 1, 1, 66, 7, 1'b0});

      // Mid-frame request is dropped with one overrun; mask snapshot keeps voice 2.
      ovr_before = ovr_cnt;
      @(negedge clk); #1;
      voice_active = 3'b111;
      voice_sample = {SW'(30), SW'(20), SW'(10)};
      dly[0] = 1; dly[1] = 1; dly[2] = 1;
      push_frame(3'b111, 60, 7);
      frame_req = 1'b1;
      @(negedge clk); #1;
      frame_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      voice_active = 3'b011;
      t_drop = neg_cnt;
      frame_req = 1'b1;
      @(negedge clk); #1;
      frame_req = 1'b0;
      wait_done();
      check("overrun_count", 32'(ovr_cnt - ovr_before), 32'd1);
      check("overrun_timing", 32'(last_ovr), 32'(t_drop + 1));

      // Request in DONE is dropped; the next cycle is accepted (empty masks).
      ovr_before = ovr_cnt;
      @(negedge clk); #1;
      voice_active = 3'b000;
      push_frame(3'b000, 0, 1);
      frame_req = 1'b1;
      @(negedge clk); #1;
      t_drop = neg_cnt;
      @(negedge clk); #1;
      push_frame(3'b000, 0, 1);
      @(negedge clk); #1;
      frame_req = 1'b0;
      wait_done();
      check("done_drop_overrun", 32'(ovr_cnt - ovr_before), 32'd1);
      check("done_drop_timing", 32'(last_ovr), 32'(t_drop + 1));
      check("total_overruns", 32'(ovr_cnt), 32'd2);
      check("gen_q_empty", 32'(exp_gen_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Sequences the shared sample-generation handshake of up to `NUM_VOICES` `note_player` instances for each codec sample period. On a frame request it pulses `generate_next_sample` to each active voice in turn, waits for that voice's `new_sample_ready`, and accumulates the signed samples. It then emits one saturated 16-bit mixed sample to the codec path. It sits between the codec frame timer and the voice bank, in place of per-voice free-running strobes.

## Interface
- `NUM_VOICES`, default 3: number of voices. Legal range is 1–8.
- `SAMPLE_W`, default 16: width of each voice sample and of the mix output.
- `TIMEOUT`, default 64: number of WAIT cycles before a voice is abandoned. Must be ≥ 2.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low. 0 resets the block.
- `frame_req` in 1: single-cycle pulse meaning a new mixed sample is needed.
- `voice_active` in NUM_VOICES: per-voice play_enable mask.
- `gen_sample` out NUM_VOICES: one-hot, single-cycle `generate_next_sample` pulses.
- `voice_ready` in NUM_VOICES: per-voice `new_sample_ready`.
- `voice_sample` in NUM_VOICES*SAMPLE_W: flattened signed samples. Voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- `mix_out` out SAMPLE_W: signed, saturated sum. Holds its value between frames.
- `mix_valid` out 1: single-cycle pulse indicating `mix_out` is new.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: single-cycle pulse when a `frame_req` is dropped.
- `timeout_err` out 1: sticky flag. Set on any voice timeout; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `frame_req`, latch `voice_active` into `mask`, clear the accumulator, and set index `idx` to the lowest set bit of `mask`.
  - Go to ISSUE. If `mask` is 0, go directly to DONE.
- **ISSUE**
  - Assert `gen_sample[idx]` for exactly this one cycle.
  - Clear the timeout counter and go to WAIT.
- **WAIT**
  - `voice_ready[idx]` is sampled here only. A ready in the ISSUE cycle is ignored.
  - On ready: add the sign-extended `voice_sample[idx]` to the accumulator.
  - On a counter reaching `TIMEOUT-1` without ready: add 0 and set `timeout_err`.
  - In either case, advance `idx` to the next set bit of `mask` above `idx` and go to ISSUE. If there is none, go to DONE.
- **DONE**
  - Drive `mix_out` = saturate(accumulator) and assert `mix_valid` for this one cycle.
  - Go to IDLE.
- `mask` is a snapshot taken at acceptance. Changes to `voice_active` mid-frame are ignored until the next frame.
- `voice_ready` from non-selected voices is ignored in all states.
- **Arithmetic**
  - Accumulator is signed, SAMPLE_W+3 bits wide.
  - Saturation clamps to the range [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. For the default width this is −32768 / 32767.
  - No wrap-around is permitted.
- **Overrun**
  - A `frame_req` arriving in any state other than IDLE is dropped, and `overrun` pulses the next cycle.
  - A `frame_req` in the DONE cycle is also dropped.
- **Reset**
  - On reset assertion, state returns to IDLE immediately (asynchronously), even mid-frame.
  - All outputs go to 0: `gen_sample`, `mix_out`, `mix_valid`, `busy`, `overrun`, `timeout_err`.
  - An in-flight frame is discarded and produces no `mix_valid`.

## Timing
- All outputs are registered. Below, t is the clock edge at which `frame_req` is sampled high in IDLE.
- `gen_sample` for the first voice is high during cycle t+1 (ISSUE).
- The earliest ready is sampled at t+2.
- Per voice, the cost is 1 ISSUE cycle plus r WAIT cycles, where r ≥ 1 is the ready delay. A timed-out voice costs 1 + TIMEOUT cycles.
- `mix_valid` is high in the cycle after the last voice's WAIT exit. `busy` falls the cycle after that.
- With an empty mask, `mix_valid` is high at t+1.
- With 3 voices that each respond 1 cycle after their pulse, `mix_valid` is high at t+7.
- Back-to-back frames: the earliest acceptable `frame_req` is the cycle after DONE.

## Structure
- `voice_pkg` holds:
  - the state enum;
  - the `SAMPLE_W` default;
  - the accumulator-width constant;
  - a `saturate` function;
  - a `next_set_bit(mask, idx)` function.
- One sub-module is natural: `mix_accumulator`. It holds the clear/add controls, the accumulator register and the saturating output.

## Test plan
- **Basic 3-voice mix:** mask 3'b111; voices answer 1 cycle after their pulse with 1000, −200 and 50 → `gen_sample` sequence 001, 010, 100; `mix_out` = 850; `mix_valid` at t+7.
- **Sparse mask and empty mask:** mask 3'b101 → only voices 0 and 2 are pulsed. Mask 0 → `mix_valid` at t+1 with `mix_out` = 0 and no `gen_sample` pulses.
- **Saturation:** three voices each returning 20000 → `mix_out` = 32767. Three voices each returning −20000 → `mix_out` = −32768.
- **Timeout:** voice 1 never asserts ready, TIMEOUT = 64 → that voice contributes 0; `timeout_err` goes high and stays high. The frame still completes 65 cycles later than it would otherwise.
- **Overrun and snapshot:** `frame_req` asserted mid-frame → one `overrun` pulse and no second `mix_valid`. Clearing `voice_active[2]` mid-frame → voice 2 is still pulsed.
- **Reset mid-WAIT:** assert reset → all outputs 0 immediately and no `mix_valid`. Release reset, then `frame_req` → a normal frame completes.
